// File: rtl/dcb_cfg_pkg.sv
// Purpose: shared types and sizing helpers for the connection-block config loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dcb_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      SET    = 2'd3
   } state_t;

   // Width of the configuration vector of one data connection block.
   function automatic int conf_width(input int w, input int datain, input int dataout);
      return w * (datain + dataout);
   endfunction

   // Stream words needed to cover the configuration vector (last word may be padded).
   function automatic int nwords(input int conf_w, input int cw);
      return (conf_w + cw - 1) / cw;
   endfunction

   // Counter width able to hold 0..n without wrapping.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Purpose: shadow register that shifts in configuration words from the top end.
// Latency: word visible in the shadow one cycle after shift_en.
// Backpressure: none; shifts whenever shift_en is high.
module cfg_shift_reg #(
   parameter int CW     = 32,
   parameter int NWORDS = 96
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 shift_en,
   input  logic [CW-1:0]        data_in,
   output logic [NWORDS*CW-1:0] shadow
);

   logic [NWORDS*CW-1:0] shadow_q;
   logic [NWORDS*CW-1:0] shadow_d;

   // New word enters at the top, so after NWORDS shifts word k sits at [k*CW +: CW].
   always_comb begin
      shadow_d = shadow_q;
      if (shift_en) begin
         shadow_d = {data_in, shadow_q[NWORDS*CW-1:CW]};
      end
   end

   // Shadow storage, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign shadow = shadow_q;

endmodule

// File: rtl/dcb_config_loader.sv
// Purpose: accumulate a config vector from a word stream and commit it atomically to c with a cset strobe.
// Latency: cset 2 cycles after the final handshake edge, done 1 cycle after cset.
// Backpressure: cfg_ready high only in LOAD; cfg_valid low stalls the load indefinitely.
module dcb_config_loader
   import dcb_cfg_pkg::*;
#(
   parameter int W       = 192,
   parameter int DATAIN  = 8,
   parameter int DATAOUT = 8,
   parameter int CW      = 32,
   localparam int CONF_WIDTH = conf_width(W, DATAIN, DATAOUT),
   localparam int NWORDS     = nwords(CONF_WIDTH, CW)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CW-1:0]         cfg_data,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic [CONF_WIDTH-1:0] c,
   output logic                  cset,
   output logic                  busy,
   output logic                  done
);

   localparam int CNTW = cnt_width(NWORDS);
   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NWORDS - 1);

   state_t                  state_q, state_d;
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic [CONF_WIDTH-1:0]   c_q, c_d;
   logic                    done_q, done_d;
   logic                    shift_en;
   logic [NWORDS*CW-1:0]    shadow;

   cfg_shift_reg #(
      .CW     (CW),
      .NWORDS (NWORDS)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .data_in  (cfg_data),
      .shadow   (shadow)
   );

   // Next-state, counter and commit logic; abort only matters while loading.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      c_d       = c_q;
      done_d    = 1'b0;
      cfg_ready = 1'b0;
      shift_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               shift_en = 1'b1;
               cnt_d    = cnt_q + CNTW'(1);
            end
            if (abort) begin
               state_d = IDLE;
            end else if (cfg_valid && (cnt_q == LAST_IDX)) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            // Padding bits above CONF_WIDTH in the last word are dropped here.
            c_d     = shadow[CONF_WIDTH-1:0];
            state_d = SET;
         end
         SET: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter, committed config and done pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         done_q  <= done_d;
      end
   end

   assign c    = c_q;
   assign cset = (state_q == SET);
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_dcb_config_loader.sv
// Purpose: randomized self-checking bench for dcb_config_loader against a word-array model of c.
// Latency: checks cset two cycles and done three cycles after the final handshake.
// Backpressure: drives cfg_valid with fixed and random gaps.
module tb_dcb_config_loader;

   localparam int CW   = 32;
   localparam int NW   = 96;
   localparam int CWID = 3072;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            abort;
   logic [CW-1:0]   cfg_data;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [CWID-1:0] c;
   logic            cset;
   logic            busy;
   logic            done;

   int vectors     = 0;
   int miscompares = 0;
   int cset_cnt    = 0;
   int done_cnt    = 0;

   // Reference model: words of the next load, and the words c should currently hold.
   logic [CW-1:0] words [NW];
   logic [CW-1:0] exp_c [NW];

   dcb_config_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .c         (c),
      .cset      (cset),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Count strobes seen mid-cycle, to catch extra or missing pulses anywhere in the run.
   always @(negedge clk) begin
      if (cset) cset_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_c(input string tag);
      for (int k = 0; k < NW; k++) begin
         chk(tag, c[k*CW +: CW], exp_c[k]);
      end
   endtask

   // 0: k, 1: all ones, 2: k ^ A5A5A5A5, 3: random
   task automatic fill(input int mode);
      for (int k = 0; k < NW; k++) begin
         case (mode)
            0:       words[k] = 32'(k);
            1:       words[k] = 32'hFFFF_FFFF;
            2:       words[k] = 32'(k) ^ 32'hA5A5_A5A5;
            default: words[k] = $urandom;
         endcase
      end
   endtask

   // Send n words starting right after the start cycle; gap_mode 0 none, 1 two idle cycles, 2 random.
   task automatic send_words(input int n, input int gap_mode, input bit spam);
      for (int k = 0; k < n; k++) begin
         int gaps;
         cfg_data  = words[k];
         cfg_valid = 1'b1;
         if (spam) start = 1'($urandom_range(0, 1));
         if (k == 0) chk("ready_in_load", cfg_ready, 1);
         step();
         cfg_valid = 1'b0;
         cfg_data  = $urandom;
         start     = 1'b0;
         gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : $urandom_range(0, 3);
         if (k < NW - 1) repeat (gaps) step();
      end
   endtask

   // One complete load; returns during the done cycle so the next call starts back-to-back.
   task automatic run_load(input int gap_mode, input bit spam, input bit late_abort);
      int c0;
      c0 = cset_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      send_words(NW, gap_mode, spam);
      abort = late_abort;
      chk("cset_not_yet", cset, 0);
      chk("no_early_cset", cset_cnt - c0, 0);
      step();
      for (int k = 0; k < NW; k++) exp_c[k] = words[k];
      chk("cset_pulse", cset, 1);
      chk("ready_low_set", cfg_ready, 0);
      check_c("c_word");
      step();
      abort = 1'b0;
      chk("done_pulse", done, 1);
      chk("cset_drop", cset, 0);
      chk("busy_idle", busy, 0);
      chk("cset_count", cset_cnt - c0, 1);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      for (int k = 0; k < NW; k++) exp_c[k] = '0;

      // Reset state
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_cset", cset, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cfg_ready, 0);
      check_c("rst_c");
      repeat (3) step();
      rst = 1'b1;
      step();

      // IDLE ignores cfg_valid and abort
      cfg_valid = 1'b1;
      abort     = 1'b1;
      chk("idle_ready", cfg_ready, 0);
      step();
      step();
      chk("idle_busy", busy, 0);
      chk("idle_ready2", cfg_ready, 0);
      cfg_valid = 1'b0;
      abort     = 1'b0;

      // Full load on consecutive cycles, then the 1/0/0 gapped stream, back-to-back
      fill(0);
      run_load(0, 1'b0, 1'b0);
      run_load(1, 1'b0, 1'b0);

      // Random data, random stalls, start spam in LOAD, abort held through COMMIT/SET
      fill(3);
      run_load(2, 1'b1, 1'b1);

      // Abort after 50 words, with a word offered in the same cycle
      begin
         int c0, d0;
         fill(3);
         step();
         c0 = cset_cnt;
         d0 = done_cnt;
         start = 1'b1;
         step();
         start = 1'b0;
         send_words(50, 0, 1'b0);
         cfg_valid = 1'b1;
         cfg_data  = $urandom;
         abort     = 1'b1;
         step();
         abort     = 1'b0;
         cfg_valid = 1'b0;
         chk("abort_busy", busy, 0);
         chk("abort_ready", cfg_ready, 0);
         repeat (5) step();
         chk("abort_no_cset", cset_cnt - c0, 0);
         chk("abort_no_done", done_cnt - d0, 0);
         check_c("abort_c_kept");
      end

      // Full load after the abort
      fill(3);
      run_load(0, 1'b0, 1'b0);

      // Asynchronous reset after 30 words
      begin
         int c0;
         fill(3);
         step();
         start = 1'b1;
         step();
         start = 1'b0;
         send_words(30, 0, 1'b0);
         cfg_valid = 1'b1;
         #2;
         rst = 1'b0;
         #1;
         for (int k = 0; k < NW; k++) exp_c[k] = '0;
         chk("mrst_busy", busy, 0);
         chk("mrst_cset", cset, 0);
         chk("mrst_done", done, 0);
         chk("mrst_ready", cfg_ready, 0);
         check_c("mrst_c");
         repeat (2) step();
         c0 = cset_cnt;
         rst = 1'b1;
         repeat (100) step();
         cfg_valid = 1'b0;
         chk("mrst_no_cset", cset_cnt - c0, 0);
         chk("mrst_idle", busy, 0);
      end

      // Overwrite: all-ones load, then patterned load started in the done cycle
      fill(1);
      run_load(0, 1'b0, 1'b0);
      fill(2);
      run_load(0, 1'b0, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound so a stuck DUT cannot hang the run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, %0d vectors, %0d miscompares", vectors, miscompares);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dcb_config_loader.md
Name: dcb_config_loader

Overview:
Loads the configuration vector of one data connection block from a word-wide stream. Words are accumulated in a shadow register, then the complete vector is committed to the block's c input with a single-cycle cset strobe. The loader sits between the fabric configuration chain and each connection block instance. The c output changes only at commit, so a partially loaded configuration never reaches the datapath.

Parameters:
W, 192, fabric wires per side
DATAIN, 8, MAC data inputs (WW-bit words)
DATAOUT, 8, MAC data outputs
CONF_WIDTH, W*(DATAIN+DATAOUT) (3072), configuration vector width
CW, 32, configuration stream word width
NWORDS, ceil(CONF_WIDTH/CW) (96), words per full load

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  begin a load; sampled only in IDLE
abort  in  1  cancel an in-progress load
cfg_data  in  CW  configuration word
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  loader accepts a word
c  out  CONF_WIDTH  committed configuration, to the connection block
cset  out  1  commit strobe, to the connection block
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse after the cset cycle

Behaviour:
- Single clock domain: clk. rst is asynchronous and active-low.
- Reset values (any state, mid-load included): state IDLE, word count 0, shadow 0, c 0, cset 0, cfg_ready 0, busy 0, done 0.
- States: IDLE, LOAD, COMMIT, SET.
- IDLE:
  - start=1 moves to LOAD and clears the word count.
  - abort is ignored.
  - cfg_valid is ignored and cfg_ready=0.
- LOAD:
  - cfg_ready=1 combinationally in this state.
  - A handshake occurs when cfg_valid=1 and cfg_ready=1.
  - On each handshake the shadow shifts right by CW: shadow <= {cfg_data, shadow[NWORDS*CW-1:CW]}. The word count increments.
  - After NWORDS handshakes, word k occupies shadow[k*CW +: CW].
  - On the handshake that brings the count to NWORDS, the next state is COMMIT.
  - cfg_valid=0 stalls the load indefinitely; no timeout.
  - abort=1 returns to IDLE on the next edge, even if a handshake occurs in the same cycle. The shadow is left stale, c is unchanged and no cset is issued.
  - start is ignored.
- COMMIT:
  - c <= shadow[CONF_WIDTH-1:0]. Shadow bits above CONF_WIDTH (padding in the last word) are discarded.
  - cfg_ready=0. Next state is SET.
- SET:
  - cset=1 for exactly this one cycle, with c already holding the new value.
  - Next state is IDLE, with done=1 registered for the following cycle.
- abort is ignored in COMMIT and SET: a commit, once started, always completes.
- Latency: cset is high in the 2nd cycle after the final handshake edge. done is high in the 3rd cycle.
- Back-to-back loads: start may be asserted in the same cycle as done. The loader is in IDLE during that cycle, so the new load is accepted.
- c holds its value across aborts and new loads until the next COMMIT.
- The word counter is ceil(log2(NWORDS+1)) bits wide and never wraps.

Decomposition:
- Shared package dcb_cfg_pkg holds:
  - the state enum {IDLE, LOAD, COMMIT, SET};
  - constant functions for CONF_WIDTH and NWORDS, and the counter width.
- Sub-module cfg_shift_reg (parameters CW, NWORDS) holds the shadow register.
  - Inputs: shift enable, data word.
  - Output: full NWORDS*CW shadow.
- The FSM, counter and commit register stay in the top module.

Test Plan:
- Full load: after reset, pulse start, then send words k=0..95 with cfg_data=k on consecutive cycles.
  - Required: c[k*32 +: 32]==k for every k.
  - cset is high exactly one cycle, 2 cycles after the last handshake.
  - done follows one cycle later.
  - busy is low again after done.
- Gapped stream: same data with cfg_valid toggling 1/0/0 between words.
  - Required: identical final c; exactly 96 handshakes; cset appears only after the 96th word.
- Abort: load words 0..49, then assert abort for one cycle together with cfg_valid.
  - Required: return to IDLE, c stays at its previous value, no cset and no done.
  - A subsequent full load succeeds.
- Ignored start: assert start repeatedly during LOAD.
  - Required: the count is not reset and c matches the full load.
- Reset mid-load: deassert rst (drive low) after 30 words.
  - Required: all outputs 0 immediately; no cset after rst returns high.
- Overwrite: first load with all words 0xFFFFFFFF, then a second load with word k = k ^ 0xA5A5A5A5.
  - Required: after the second cset, c reflects the second pattern only.
  - start is accepted in the same cycle as the first load's done.
